// File: rtl/osm_product_acc.sv
// rtl/osm_product_acc.sv - product accumulator for the sequential 8x8 multiplier (option: OSM_ACC_SAT_EN saturates on overflow)
module osm_product_acc #(
  parameter int ACC_W   = 18,
  parameter int N_TERMS = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clear,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic [3:0]       term_cnt,
  output logic             overflow,
  output logic             dropped
);

  // Zero-extension width that lifts the 16-bit product to the ACC_W+1 bit adder.
  localparam int PAD = ACC_W + 1 - 16;
  localparam logic [3:0] LAST_TERM = 4'(N_TERMS);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic             pv_q;
  logic             capture;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_kept;
  logic [3:0]       cnt_inc;
  logic [ACC_W-1:0] acc_nx;
  logic [3:0]       cnt_nx;
  logic             ovf_nx;
  logic             drp_nx;

  // The multiplier holds out_valid for several cycles, so only its rising edge counts.
  assign capture = prod_valid & ~pv_q;

  // One extra bit on the adder exposes the carry that marks an overflow.
  assign sum     = {1'b0, acc_out} + {{PAD{1'b0}}, prod_in};
  assign cnt_inc = term_cnt + 4'd1;

`ifdef OSM_ACC_SAT_EN
  // Pin the sum at all ones once it no longer fits; later terms keep it there.
  assign sum_kept = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  // Let the sum wrap modulo 2^ACC_W; the sticky flag records that it happened.
  assign sum_kept = sum[ACC_W-1:0];
`endif

  // Previous level of prod_valid for the edge detector; keeps tracking during clear.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pv_q <= 1'b0;
    end else begin
      pv_q <= prod_valid;
    end
  end

  // Next-state and datapath decisions; clear overrides any capture in the same cycle.
  always_comb begin
    state_nx = state;
    acc_nx   = acc_out;
    cnt_nx   = term_cnt;
    ovf_nx   = overflow;
    drp_nx   = dropped;
    if (clear) begin
      state_nx = S_ACCUM;
      acc_nx   = '0;
      cnt_nx   = 4'd0;
      ovf_nx   = 1'b0;
      drp_nx   = 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (capture) begin
            acc_nx = sum_kept;
            cnt_nx = cnt_inc;
            if (sum[ACC_W]) begin
              ovf_nx = 1'b1;
            end
            if (cnt_inc == LAST_TERM) begin
              state_nx = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (capture) begin
            drp_nx = 1'b1;
          end
        end
        default: begin
          state_nx = S_ACCUM;
        end
      endcase
    end
  end

  // State and output registers; acc_valid is a flop so no input reaches an output combinationally.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= S_ACCUM;
      acc_out   <= '0;
      term_cnt  <= 4'd0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      acc_out   <= acc_nx;
      term_cnt  <= cnt_nx;
      overflow  <= ovf_nx;
      dropped   <= drp_nx;
      acc_valid <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_osm_product_acc.sv
// tb/tb_osm_product_acc.sv - directed scoreboard bench for osm_product_acc
module tb_osm_product_acc;

  localparam int ACC_W = 18;
  localparam longint MAX18 = (64'd1 << ACC_W) - 1;

  logic             CLK;
  logic             reset;
  logic             clear;
  logic [15:0]      prod_in;
  logic             prod_valid;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic [3:0]       term_cnt;
  logic             overflow;
  logic             dropped;

  logic             clr16;
  logic [15:0]      p16;
  logic             pv16;
  logic [15:0]      acc16;
  logic             av16;
  logic [3:0]       cnt16;
  logic             ovf16;
  logic             drp16;

  osm_product_acc u_dut (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (clear),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .term_cnt   (term_cnt),
    .overflow   (overflow),
    .dropped    (dropped)
  );

  osm_product_acc #(.ACC_W(16), .N_TERMS(4)) u_dut16 (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (clr16),
    .prod_in    (p16),
    .prod_valid (pv16),
    .acc_out    (acc16),
    .acc_valid  (av16),
    .term_cnt   (cnt16),
    .overflow   (ovf16),
    .dropped    (drp16)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic [31:0] vld;
    logic [31:0] ovf;
    logic [31:0] drp;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  longint m_acc;
  int     m_cnt;
  logic   m_done;
  logic   m_ovf;
  logic   m_drp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_zero();
    m_acc  = 0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_drp  = 1'b0;
  endtask

  task automatic model_capture(input logic [15:0] p);
    exp_t e;
    longint s;
    if (m_done) begin
      m_drp = 1'b1;
    end else begin
      s = m_acc + longint'(p);
      if (s > MAX18) begin
        m_ovf = 1'b1;
`ifdef OSM_ACC_SAT_EN
        s = MAX18;
`else
        s = s - (MAX18 + 1);
`endif
      end
      m_acc = s;
      m_cnt++;
      if (m_cnt == 4) m_done = 1'b1;
    end
    e.acc = 32'(m_acc);
    e.cnt = 32'(m_cnt);
    e.vld = {31'd0, m_done};
    e.ovf = {31'd0, m_ovf};
    e.drp = {31'd0, m_drp};
    sbq.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_acc"}, 32'(acc_out),   e.acc);
      chk({tag, "_cnt"}, 32'(term_cnt),  e.cnt);
      chk({tag, "_vld"}, 32'(acc_valid), e.vld);
      chk({tag, "_ovf"}, 32'(overflow),  e.ovf);
      chk({tag, "_drp"}, 32'(dropped),   e.drp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input string tag, input logic [15:0] p, input int hi, input int lo);
    prod_in    = p;
    prod_valid = 1'b1;
    model_capture(p);
    @(negedge CLK);
    pop_check(tag);
    repeat (hi - 1) @(negedge CLK);
    prod_valid = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_acc"}, 32'(acc_out),   32'd0);
    chk({tag, "_cnt"}, 32'(term_cnt),  32'd0);
    chk({tag, "_vld"}, 32'(acc_valid), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow),  32'd0);
    chk({tag, "_drp"}, 32'(dropped),   32'd0);
  endtask

  task automatic send16(input logic [15:0] p);
    p16  = p;
    pv16 = 1'b1;
    @(negedge CLK);
    pv16 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    reset      = 1'b0;
    clear      = 1'b0;
    prod_in    = 16'd0;
    prod_valid = 1'b0;
    clr16      = 1'b0;
    p16        = 16'd0;
    pv16       = 1'b0;
    model_zero();

    repeat (2) @(negedge CLK);
    check_zero("reset_idle");
    reset = 1'b1;
    @(negedge CLK);

    // Reset asserted mid-cycle with prod_valid high, then capture on first edge after release.
    send("pre", 16'd10, 2, 1);
    prod_in    = 16'd7;
    prod_valid = 1'b1;
    #2 reset = 1'b0;
    #1 check_zero("reset_async");
    @(negedge CLK);
    reset = 1'b1;
    model_zero();
    model_capture(16'd7);
    @(negedge CLK);
    pop_check("reset_release");
    prod_valid = 1'b0;
    repeat (2) @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    model_zero();
    check_zero("clear_basic");

    // Normal run of four products, each held three cycles with two low cycles between.
    send("t2_p1", 16'd27,   3, 2);
    send("t2_p2", 16'd0,    3, 2);
    send("t2_p3", 16'd1400, 3, 2);
    send("t2_p4", 16'd1476, 3, 2);
    chk("t2_sum",   32'(acc_out),   32'd2903);
    chk("t2_cnt",   32'(term_cnt),  32'd4);
    chk("t2_valid", 32'(acc_valid), 32'd1);
    chk("t2_ovf",   32'(overflow),  32'd0);

    // Product arriving in DONE is dropped.
    send("t3_drop", 16'd3105, 3, 2);
    chk("t3_sum",   32'(acc_out),   32'd2903);
    chk("t3_drp",   32'(dropped),   32'd1);
    chk("t3_valid", 32'(acc_valid), 32'd1);

    // clear on the same edge as a rising prod_valid: clear wins and 500 is lost.
    clear      = 1'b1;
    prod_in    = 16'd500;
    prod_valid = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    model_zero();
    check_zero("t4_clear");
    @(negedge CLK);
    chk("t4_no_late_capture", 32'(term_cnt), 32'd0);
    chk("t4_acc_hold",        32'(acc_out),  32'd0);
    prod_valid = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset in the middle of an accumulation, then restart with four ones.
    send("t6_p1", 16'd27,   2, 1);
    send("t6_p2", 16'd1400, 2, 1);
    chk("t6_partial", 32'(acc_out), 32'd1427);
    #2 reset = 1'b0;
    #1 check_zero("t6_reset");
    @(negedge CLK);
    reset = 1'b1;
    model_zero();
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      send("t6_one", 16'd1, 1, 1);
    end
    chk("t6_sum",   32'(acc_out),   32'd4);
    chk("t6_valid", 32'(acc_valid), 32'd1);

    // Overflow on the 16-bit instance.
    send16(16'd65025);
    chk("t5_first", 32'(acc16), 32'd65025);
    chk("t5_first_ovf", 32'(ovf16), 32'd0);
    send16(16'd65025);
`ifdef OSM_ACC_SAT_EN
    chk("t5_sum_sat", 32'(acc16), 32'd65535);
`else
    chk("t5_sum_wrap", 32'(acc16), 32'd64514);
`endif
    chk("t5_ovf",   32'(ovf16), 32'd1);
    chk("t5_cnt",   32'(cnt16), 32'd2);
    chk("t5_valid", 32'(av16),  32'd0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
